// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// default memory depth and the requester port-id type.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEPTH = 65536;

    typedef logic port_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: purely combinational; the parent owns the
// priority pointer and advances it on handshake.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic     valid0,
    input  logic     valid1,
    input  port_id_t prio,
    output logic     grant_valid,
    output port_id_t grant
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = prio;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU port (0) and the loader
// port (1); one access in flight, handshake -> ISSUE -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    dmem_state_t       state_reg, state_next;
    port_id_t          prio_reg;
    port_id_t          lat_port_reg;
    logic              lat_write_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg;
    logic              err_reg;

    logic              grant_valid;
    port_id_t          grant;
    logic              in_range;
    logic              handshake;
    logic [1:0]        ready_vec;
    logic [1:0]        rsp_valid_vec;
    logic [1:0]        rsp_err_vec;
    logic [DATA_W-1:0] rsp_rdata_vec [2];
    logic [DATA_W-1:0] rdata_reg     [2];
    logic [DATA_W-1:0] rsp_data_next;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .prio        (prio_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign in_range  = {1'b0, lat_addr_reg} < DEPTH_EXT;
    assign handshake = (state_reg == IDLE) && grant_valid;

    always_comb begin
        state_next = state_reg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_read   = in_range && !lat_write_reg;
                mem_write  = in_range && lat_write_reg;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            lat_port_reg  <= 1'b0;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                lat_port_reg  <= grant;
                lat_write_reg <= grant ? req1_write : req0_write;
                lat_addr_reg  <= grant ? req1_addr  : req0_addr;
                lat_wdata_reg <= grant ? req1_wdata : req0_wdata;
                prio_reg      <= ~grant;
            end
            if (state_reg == ISSUE) begin
                err_reg <= !in_range;
            end
        end
    end

    assign mem_addr  = lat_addr_reg;
    assign mem_wdata = lat_wdata_reg;

    // Memory read data arrives in RESP; it is forwarded straight out and also
    // captured so the port keeps showing it until its next response.
    assign rsp_data_next = (lat_write_reg || err_reg) ? '0 : mem_rdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic sel;
        assign sel                = (state_reg == RESP) && (lat_port_reg == port_id_t'(gi));
        assign rsp_valid_vec[gi]  = sel;
        assign rsp_err_vec[gi]    = sel && err_reg;
        assign rsp_rdata_vec[gi]  = sel ? rsp_data_next : rdata_reg[gi];
        assign ready_vec[gi]      = handshake && (grant == port_id_t'(gi));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_reg[gi] <= '0;
            end else if (sel) begin
                rdata_reg[gi] <= rsp_data_next;
            end
        end
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_err   = rsp_err_vec[0];
    assign rsp1_err   = rsp_err_vec[1];
    assign rsp0_rdata = rsp_rdata_vec[0];
    assign rsp1_rdata = rsp_rdata_vec[1];

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`datamem`) between two requesters: port 0 is the CPU load/store stage, port 1 is the test/loader port.
- Each requester has a valid/ready command channel and a one-cycle response pulse.
- Arbitration is round-robin, with one access in flight at a time.
- Drives the `datamem` read/write strobes and accounts for its one-cycle registered read latency.

Parameters:
- ADDR_W, 32, address width of requests and memory port.
- DATA_W, 32, data width.
- MEM_DEPTH, 65536, number of valid memory words; addresses at or above this are rejected.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- req0_valid / req1_valid  input  1  command present.
- req0_ready / req1_ready  output  1  command accepted this cycle.
- req0_write / req1_write  input  1  1 = store, 0 = load.
- req0_addr / req1_addr  input  ADDR_W  word address.
- req0_wdata / req1_wdata  input  DATA_W  store data.
- rsp0_valid / rsp1_valid  output  1  one-cycle response pulse.
- rsp0_rdata / rsp1_rdata  output  DATA_W  load data; 0 for stores and errors.
- rsp0_err / rsp1_err  output  1  address out of range, qualified by rspN_valid.
- mem_read  output  1  to `datamem` read.
- mem_write  output  1  to `datamem` write.
- mem_addr  output  ADDR_W  to `datamem` addr.
- mem_wdata  output  DATA_W  to `datamem` in.
- mem_rdata  input  DATA_W  from `datamem` out; valid the cycle after mem_read is sampled.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only when its valid is high.
  - Grant rule: if only one valid, grant it. If both valid, grant the port named by priority pointer `prio`.
  - On handshake, latch port id, write, addr, wdata. Set `prio` to the other port. Go to ISSUE.
  - With no valid, stay in IDLE; `prio` is unchanged.
- ISSUE (exactly one cycle):
  - In range (addr < MEM_DEPTH): drive mem_addr/mem_wdata from the latch, and assert exactly one of mem_read (load) or mem_write (store).
  - Out of range: no strobe, set the error flag.
  - Always go to RESP.
- RESP (one cycle):
  - Assert rsp_valid for the latched port only.
  - Load: rsp_rdata = mem_rdata, registered into the output.
  - Store: rsp_rdata = 0.
  - Error: rsp_err = 1, rsp_rdata = 0.
  - Go to IDLE.
- Both ready outputs are low in ISSUE and RESP.
- Latency: handshake edge → ISSUE cycle → RESP cycle. Response appears 2 cycles after acceptance. Peak throughput is 1 access per 3 cycles.
- Loaded data stays in rspN_rdata until that port's next response. rsp_valid and rsp_err are pulses.
- mem_read/mem_write are never high together, and never high outside ISSUE.
- mem_addr/mem_wdata hold the last latched values when idle (no glitch requirement).
- Requester must hold valid and payload stable until ready. A dropped valid before grant is legal and is simply not serviced.
- Reset values (rst_n low at a posedge):
  - State = IDLE, `prio` = 0.
  - All rsp*, mem_read, mem_write = 0; rdata and latch registers = 0.
- Reset mid-operation: the in-flight access is abandoned with no response. A store already strobed in ISSUE has completed in memory.
- Back-to-back: a requester may re-assert valid in the RESP cycle; it is granted in the next IDLE cycle, subject to `prio`.
- Address wrap: none. Out-of-range is an error, never aliased.

Decomposition:
- Shared package `dmem_pkg`:
  - FSM state enum `dmem_state_t` (IDLE, ISSUE, RESP).
  - Constant `DMEM_DEPTH` = 65536.
  - Port-id type (1 bit).
- Sub-module `rr_arb2`: combinational two-requester round-robin grant from the valids and `prio`, with the pointer update kept in the parent.

Test Plan:
- Reset, then req0 load addr 5 (memory preloaded mem[i]=i) → req0_ready at cycle 0, mem_read high at cycle 1 with mem_addr 5, rsp0_valid at cycle 2 with rsp0_rdata 5, rsp0_err 0.
- req1 store addr 10, wdata 0xDEADBEEF, then req1 load addr 10 → mem_write pulse once, rsp1_rdata 0 for the store, then rsp1_rdata 0xDEADBEEF for the load.
- Both valid continuously, loads to addrs 1 (port 0) and 2 (port 1) → grants alternate 0,1,0,1. Each gets a response every 6 cycles, and rdata matches its address.
- req0 load addr 70000 → no mem_read/mem_write; rsp0_valid with rsp0_err 1, rsp0_rdata 0.
- rst_n low during ISSUE of a req0 load → no rsp0_valid. After release, state is IDLE and `prio` is 0: both valid gives the grant to port 0.
- req0 holds valid into its own RESP cycle → re-grant on the next IDLE cycle, with no lost or duplicated responses.
